// File: rtl/cuckoo_l15_loader_if.sv
// cuckoo_l15_loader_if: insert request, pattern/index RAM write and completion bus; stat counters present with CUCKOO_LOADER_STATS_EN
interface cuckoo_l15_loader_if #(
   parameter int PTR_W  = 9,
   parameter int HASH_W = 10,
   parameter int PAT_W  = 122
);
   logic              in_valid;
   logic              in_ready;
   logic [HASH_W-1:0] in_h1;
   logic [HASH_W-1:0] in_h2;
   logic [PTR_W-1:0]  in_ptr;
   logic [PAT_W-1:0]  in_pattern;
   logic              pat_we;
   logic [PTR_W-1:0]  pat_addr;
   logic [PAT_W-1:0]  pat_din;
   logic              idx_we;
   logic [HASH_W:0]   idx_addr;
   logic [PTR_W-1:0]  idx_din;
   logic              done_valid;
   logic              done_fail;
   logic [PTR_W-1:0]  done_ptr;
   logic [4:0]        done_kicks;
`ifdef CUCKOO_LOADER_STATS_EN
   logic [15:0]       stat_inserts;
   logic [15:0]       stat_fails;
`endif
   modport master (
`ifdef CUCKOO_LOADER_STATS_EN
      input  stat_inserts, stat_fails,
`endif
      output in_valid, in_h1, in_h2, in_ptr, in_pattern,
      input  in_ready, pat_we, pat_addr, pat_din, idx_we, idx_addr, idx_din,
      input  done_valid, done_fail, done_ptr, done_kicks
   );
   modport slave (
`ifdef CUCKOO_LOADER_STATS_EN
      output stat_inserts, stat_fails,
`endif
      input  in_valid, in_h1, in_h2, in_ptr, in_pattern,
      output in_ready, pat_we, pat_addr, pat_din, idx_we, idx_addr, idx_din,
      output done_valid, done_fail, done_ptr, done_kicks
   );
endinterface

// File: rtl/cuckoo_l15_loader.sv
// cuckoo_l15_loader: cuckoo-displacement insert engine with shadow index RAM; CUCKOO_LOADER_STATS_EN adds insert/fail counters
module cuckoo_l15_loader #(
   parameter int PTR_W     = 9,
   parameter int HASH_W    = 10,
   parameter int PAT_W     = 122,
   parameter int MAX_KICKS = 16
) (
   input logic                clk,
   input logic                rst,
   cuckoo_l15_loader_if.slave bus
);
   localparam int A_W   = HASH_W + 1;
   localparam int DEPTH = 1 << A_W;
   localparam int E_W   = 1 + PTR_W + A_W;
   typedef enum logic [2:0] {INIT, IDLE, RD, CHK, DONE} state_t;
   typedef enum logic [1:0] {FIRST, SECOND, KICKED} mode_t;
   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [A_W-1:0]   cnt_q, cnt_d;
   logic [A_W-1:0]   cur_addr_q, cur_addr_d;
   logic [A_W-1:0]   cur_alt_q, cur_alt_d;
   logic [PTR_W-1:0] cur_ptr_q, cur_ptr_d;
   logic [4:0]       kicks_q, kicks_d;
   logic             fail_q, fail_d;
   logic             pat_we_q, pat_we_d;
   logic [PTR_W-1:0] pat_addr_q, pat_addr_d;
   logic [PAT_W-1:0] pat_din_q, pat_din_d;
   logic [E_W-1:0]   mem [DEPTH];
   logic [E_W-1:0]   rd_q;
   logic             sh_we;
   logic [A_W-1:0]   sh_addr;
   logic [E_W-1:0]   sh_din;
   logic             ov;
   logic [PTR_W-1:0] optr;
   logic [A_W-1:0]   oalt;
   logic             live;
   assign {ov, optr, oalt} = rd_q;
   assign live = !rst;
   // shadow RAM: one write per cycle, registered read of the current probe address
   always_ff @(posedge clk) begin
      if (sh_we) mem[sh_addr] <= sh_din;
      rd_q <= mem[cur_addr_q];
   end
   // FSM state, insert context and pattern write register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= INIT;
         mode_q     <= FIRST;
         cnt_q      <= '0;
         cur_addr_q <= '0;
         cur_alt_q  <= '0;
         cur_ptr_q  <= '0;
         kicks_q    <= '0;
         fail_q     <= 1'b0;
         pat_we_q   <= 1'b0;
         pat_addr_q <= '0;
         pat_din_q  <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         cur_addr_q <= cur_addr_d;
         cur_alt_q  <= cur_alt_d;
         cur_ptr_q  <= cur_ptr_d;
         kicks_q    <= kicks_d;
         fail_q     <= fail_d;
         pat_we_q   <= pat_we_d;
         pat_addr_q <= pat_addr_d;
         pat_din_q  <= pat_din_d;
      end
   end
   // next state: init sweep, accept, probe/kick decision; the shadow write doubles as the index RAM write
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      cnt_d      = cnt_q;
      cur_addr_d = cur_addr_q;
      cur_alt_d  = cur_alt_q;
      cur_ptr_d  = cur_ptr_q;
      kicks_d    = kicks_q;
      fail_d     = fail_q;
      pat_we_d   = 1'b0;
      pat_addr_d = '0;
      pat_din_d  = '0;
      sh_we      = 1'b0;
      sh_addr    = cur_addr_q;
      sh_din     = {1'b1, cur_ptr_q, cur_alt_q};
      case (state_q)
         INIT: begin
            sh_we   = 1'b1;
            sh_addr = cnt_q;
            sh_din  = '0;
            cnt_d   = cnt_q + 1'b1;
            state_d = &cnt_q ? IDLE : INIT;
         end
         IDLE: if (bus.in_valid) begin
            cur_ptr_d  = bus.in_ptr;
            cur_addr_d = {1'b0, bus.in_h1};
            cur_alt_d  = {1'b1, bus.in_h2};
            mode_d     = FIRST;
            kicks_d    = '0;
            fail_d     = 1'b0;
            pat_we_d   = 1'b1;
            pat_addr_d = bus.in_ptr;
            pat_din_d  = bus.in_pattern;
            state_d    = RD;
         end
         RD: state_d = CHK;
         CHK: begin
            if (!ov) begin
               sh_we   = 1'b1;
               fail_d  = 1'b0;
               state_d = DONE;
            end else if (mode_q == FIRST) begin
               cur_addr_d = cur_alt_q;
               cur_alt_d  = cur_addr_q;
               mode_d     = SECOND;
               state_d    = RD;
            end else if (kicks_q < 5'(MAX_KICKS)) begin
               sh_we      = 1'b1;
               cur_ptr_d  = optr;
               cur_alt_d  = cur_addr_q;
               cur_addr_d = oalt;
               kicks_d    = kicks_q + 5'd1;
               mode_d     = KICKED;
               state_d    = RD;
            end else begin
               fail_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = INIT;
      endcase
   end
   assign bus.in_ready   = live && state_q == IDLE;
   assign bus.idx_we     = live && sh_we;
   assign bus.idx_addr   = bus.idx_we ? sh_addr : '0;
   assign bus.idx_din    = bus.idx_we ? sh_din[A_W +: PTR_W] : '0;
   assign bus.pat_we     = pat_we_q;
   assign bus.pat_addr   = pat_addr_q;
   assign bus.pat_din    = pat_din_q;
   assign bus.done_valid = live && state_q == DONE;
   assign bus.done_fail  = bus.done_valid && fail_q;
   assign bus.done_ptr   = bus.done_valid ? cur_ptr_q : '0;
   assign bus.done_kicks = bus.done_valid ? kicks_q : '0;
`ifdef CUCKOO_LOADER_STATS_EN
   logic [15:0] stat_inserts_q, stat_inserts_d;
   logic [15:0] stat_fails_q, stat_fails_d;
   // saturating completion counters
   always_comb begin
      stat_inserts_d = stat_inserts_q + 16'(bus.done_valid && !fail_q && !(&stat_inserts_q));
      stat_fails_d   = stat_fails_q + 16'(bus.done_valid && fail_q && !(&stat_fails_q));
   end
   // counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_inserts_q <= '0;
         stat_fails_q   <= '0;
      end else begin
         stat_inserts_q <= stat_inserts_d;
         stat_fails_q   <= stat_fails_d;
      end
   end
   assign bus.stat_inserts = stat_inserts_q;
   assign bus.stat_fails   = stat_fails_q;
`endif
endmodule

// File: tb/tb_cuckoo_l15_loader.sv
// tb_cuckoo_l15_loader: randomized self-checking bench against a table-level cuckoo model
module tb_cuckoo_l15_loader;
   localparam int PTR_W = 9, HASH_W = 10, PAT_W = 122, MAX_KICKS = 16, DEPTH = 2048;
   typedef struct {int cyc; int addr; int din;} wr_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   cuckoo_l15_loader_if #(.PTR_W(PTR_W), .HASH_W(HASH_W), .PAT_W(PAT_W)) bus();
   cuckoo_l15_loader #(.PTR_W(PTR_W), .HASH_W(HASH_W), .PAT_W(PAT_W), .MAX_KICKS(MAX_KICKS)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   logic [PTR_W-1:0] ram [DEPTH];
   always @(posedge clk) if (bus.idx_we) ram[bus.idx_addr] <= bus.idx_din;
   bit m_v [DEPTH];
   int m_p [DEPTH];
   int m_alt [DEPTH];
   int m_ins, m_fail;
   wr_t exp_w[$];
   wr_t got_w[$];
   int exp_done, exp_ptr, exp_kicks;
   bit exp_fail;
   function automatic void model_clear();
      foreach (m_v[i]) begin
         m_v[i] = 0;
         m_p[i] = 0;
         m_alt[i] = 0;
      end
      m_ins = 0;
      m_fail = 0;
   endfunction
   function automatic void model_insert(input int h1, input int h2, input int ptr);
      int addr = h1, alt = 1024 + h2, p = ptr, n = 0, k = 0;
      bit first = 1;
      exp_w.delete();
      exp_fail = 0;
      forever begin
         n++;
         if (!m_v[addr]) begin
            m_v[addr] = 1;
            m_p[addr] = p;
            m_alt[addr] = alt;
            exp_w.push_back('{2 * n, addr, p});
            break;
         end
         if (first) begin
            int t = addr;
            addr = alt;
            alt = t;
            first = 0;
         end else if (k == MAX_KICKS) begin
            exp_fail = 1;
            break;
         end else begin
            int dp = m_p[addr], da = m_alt[addr];
            m_p[addr] = p;
            m_alt[addr] = alt;
            exp_w.push_back('{2 * n, addr, p});
            p = dp;
            alt = addr;
            addr = da;
            k++;
         end
      end
      exp_done = 2 * n + 1;
      exp_ptr = p;
      exp_kicks = k;
      if (exp_fail) m_fail++;
      else m_ins++;
   endfunction
   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
      repeat (2048) begin @(posedge clk); #1; end
      model_clear();
   endtask
   task automatic insert(input int h1, input int h2, input int ptr, input logic [PAT_W-1:0] pat, input bit noise, input string nm);
      int dcyc = -1, pcount = 0, pc = 0, paddr = 0, dptr = 0, dkicks = 0;
      logic [PAT_W-1:0] pdin = '0;
      bit dfail = 0, wbad = 0;
      model_insert(h1, h2, ptr);
      got_w.delete();
      bus.in_valid = 1'b1;
      bus.in_h1 = HASH_W'(h1);
      bus.in_h2 = HASH_W'(h2);
      bus.in_ptr = PTR_W'(ptr);
      bus.in_pattern = pat;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_at_accept got %b want 1", nm, bus.in_ready); end
      for (int c = 1; c <= 60 && dcyc < 0; c++) begin
         @(posedge clk); #1;
         bus.in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.in_h1 = HASH_W'($urandom);
         bus.in_h2 = HASH_W'($urandom);
         bus.in_ptr = PTR_W'($urandom);
         bus.in_pattern = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         if (bus.pat_we) begin pcount++; pc = c; paddr = int'(bus.pat_addr); pdin = bus.pat_din; end
         if (bus.idx_we) got_w.push_back('{c, int'(bus.idx_addr), int'(bus.idx_din)});
         if (bus.done_valid) begin dcyc = c; dfail = bus.done_fail; dptr = int'(bus.done_ptr); dkicks = int'(bus.done_kicks); end
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++;
      if (dcyc != exp_done) begin errors++; $display("FAIL %s done_cycle got %0d want %0d", nm, dcyc, exp_done); end
      checks++;
      if (dfail != exp_fail || dptr != exp_ptr || dkicks != exp_kicks) begin
         errors++;
         $display("FAIL %s done_fields got fail=%0d ptr=%0d kicks=%0d want fail=%0d ptr=%0d kicks=%0d", nm, dfail, dptr, dkicks, exp_fail, exp_ptr, exp_kicks);
      end
      checks++;
      if (pcount != 1 || pc != 1 || paddr != ptr || pdin !== pat) begin
         errors++;
         $display("FAIL %s pat_write got count=%0d cyc=%0d addr=%0d din=%h want count=1 cyc=1 addr=%0d din=%h", nm, pcount, pc, paddr, pdin, ptr, pat);
      end
      if (got_w.size() != exp_w.size()) wbad = 1;
      else foreach (exp_w[i]) if (got_w[i].cyc != exp_w[i].cyc || got_w[i].addr != exp_w[i].addr || got_w[i].din != exp_w[i].din) wbad = 1;
      checks++;
      if (wbad) begin
         errors++;
         $display("FAIL %s idx_writes got n=%0d first=(c%0d,%h,%0d) want n=%0d first=(c%0d,%h,%0d)", nm, got_w.size(),
                  got_w.size() ? got_w[0].cyc : -1, got_w.size() ? got_w[0].addr : -1, got_w.size() ? got_w[0].din : -1,
                  exp_w.size(), exp_w.size() ? exp_w[0].cyc : -1, exp_w.size() ? exp_w[0].addr : -1, exp_w.size() ? exp_w[0].din : -1);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_after_done got %b want 1", nm, bus.in_ready); end
   endtask
   task automatic check_ram(input string nm);
      int bad = 0, first = -1;
      for (int a = 0; a < DEPTH; a++) begin
         logic [PTR_W-1:0] e = m_v[a] ? PTR_W'(m_p[a]) : '0;
         if (ram[a] !== e) begin bad++; if (first < 0) first = a; end
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL %s index_ram got %0d bad entries (first at %h) want 0", nm, bad, first); end
   endtask
   task automatic check_sweep(input string nm);
      int bad = 0;
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clk);
         if (!(bus.idx_we === 1'b1 && int'(bus.idx_addr) == k && bus.idx_din === '0 && bus.in_ready === 1'b0)) bad++;
      end
      @(negedge clk);
      checks++;
      if (bad != 0) begin errors++; $display("FAIL %s init_sweep got %0d bad cycles want 0", nm, bad); end
      checks++;
      if (bus.in_ready !== 1'b1 || bus.idx_we !== 1'b0) begin
         errors++;
         $display("FAIL %s ready_at_2048 got ready=%b idx_we=%b want ready=1 idx_we=0", nm, bus.in_ready, bus.idx_we);
      end
      @(posedge clk); #1;
      model_clear();
   endtask
   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++;
      if (bus.idx_we !== 1'b0 || bus.in_ready !== 1'b0 || bus.done_valid !== 1'b0 || bus.pat_we !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs got idx_we=%b ready=%b done=%b pat_we=%b want all 0", bus.idx_we, bus.in_ready, bus.done_valid, bus.pat_we);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      check_sweep("reset");
      check_ram("reset");
   endtask
   task automatic test_empty_insert();
      insert(5, 7, 3, PAT_W'(12'hABC), 0, "empty");
   endtask
   task automatic test_t1_collision();
      insert(5, 9, 4, PAT_W'(32'hDEAD_BEEF), 0, "t1_collision");
      check_ram("t1_collision");
   endtask
   task automatic test_kick_fail();
      do_reset();
      insert(5, 7, 1, PAT_W'(1), 0, "kick_a");
      insert(5, 7, 2, PAT_W'(2), 0, "kick_b");
      insert(5, 9, 4, PAT_W'(4), 0, "kick_d");
      insert(5, 7, 3, PAT_W'(3), 0, "kick_c");
      check_ram("kick");
`ifdef CUCKOO_LOADER_STATS_EN
      checks++;
      if (int'(bus.stat_inserts) != m_ins || int'(bus.stat_fails) != m_fail) begin
         errors++;
         $display("FAIL stats got inserts=%0d fails=%0d want inserts=%0d fails=%0d", bus.stat_inserts, bus.stat_fails, m_ins, m_fail);
      end
`endif
   endtask
   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 80; i++)
         insert($urandom_range(0, 31), $urandom_range(0, 31), i + 10, {$urandom, $urandom, $urandom, $urandom}, 1'b1, "random");
      check_ram("random");
`ifdef CUCKOO_LOADER_STATS_EN
      checks++;
      if (int'(bus.stat_inserts) != m_ins || int'(bus.stat_fails) != m_fail) begin
         errors++;
         $display("FAIL stats_random got inserts=%0d fails=%0d want inserts=%0d fails=%0d", bus.stat_inserts, bus.stat_fails, m_ins, m_fail);
      end
`endif
   endtask
   task automatic test_reset_mid();
      int bad = 0;
      do_reset();
      insert(5, 7, 1, PAT_W'(1), 0, "mid_a");
      insert(5, 7, 2, PAT_W'(2), 0, "mid_b");
      bus.in_valid = 1'b1;
      bus.in_h1 = HASH_W'(5);
      bus.in_h2 = HASH_W'(7);
      bus.in_ptr = PTR_W'(3);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.done_valid !== 1'b0) bad++;
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
      end
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (bus.done_valid !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      rst = 1'b0;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL reset_mid done_pulse got %0d pulses want 0", bad); end
      check_sweep("reset_mid");
      checks++;
      if (ram[5] !== '0) begin errors++; $display("FAIL reset_mid lookup_005 got %0d want 0", ram[5]); end
      check_ram("reset_mid");
      insert(5, 7, 9, PAT_W'(9), 0, "after_mid");
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_h1 = '0;
      bus.in_h2 = '0;
      bus.in_ptr = '0;
      bus.in_pattern = '0;
      test_reset();
      test_empty_insert();
      test_t1_collision();
      test_kick_fail();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cuckoo_l15_loader.md
Name: cuckoo_l15_loader

Overview:
- Write-side companion to the two-stage cuckoo lookup pipeline.
- Accepts pattern-insert requests carrying precomputed bucket hashes, a pattern-slot pointer and pattern data.
- Writes the pattern RAM, then places the pointer into the 2x1024 index RAM using cuckoo displacement, with a bounded kick count.
- Keeps an internal shadow of the index RAM, because the lookup pipeline's index RAM is read-only from this side.

Parameters:
- PTR_W, 9, pattern-slot pointer width (index RAM data width).
- HASH_W, 10, per-table bucket address width.
- PAT_W, 122, pattern RAM word width.
- MAX_KICKS, 16, maximum evictions per insert before failure.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  insert request valid.
- in_ready  out  1  loader can accept a request.
- in_h1  in  HASH_W  T1 bucket.
- in_h2  in  HASH_W  T2 bucket.
- in_ptr  in  PTR_W  pattern slot.
- in_pattern  in  PAT_W  pattern word.
- pat_we  out  1  pattern RAM write strobe.
- pat_addr  out  PTR_W  pattern RAM address.
- pat_din  out  PAT_W  pattern RAM data.
- idx_we  out  1  index RAM write strobe.
- idx_addr  out  HASH_W+1  index RAM address; MSB=0 selects T1, MSB=1 selects T2.
- idx_din  out  PTR_W  index RAM data.
- done_valid  out  1  one-cycle completion pulse.
- done_fail  out  1  insert failed (kick limit reached).
- done_ptr  out  PTR_W  on fail, the pointer left without a slot; else the inserted ptr.
- done_kicks  out  5  evictions used by this insert.

Behaviour:
- Shadow memory: 2048 entries of {valid, ptr[8:0], alt[10:0]}, internal. Synchronous read, 1-cycle latency; one write per cycle.
- States: INIT, IDLE, RD, CHK, DONE.
- Reset:
  - All outputs go to 0 and the FSM enters INIT with sweep counter 0.
  - In INIT, each cycle writes shadow[cnt] with valid=0 and drives idx_we=1, idx_addr=cnt, idx_din=0.
  - After cnt=2047 the FSM moves to IDLE. in_ready first goes high 2048 cycles after rst deasserts.
- in_ready = (state==IDLE). A request is accepted when in_valid && in_ready.
- On accept:
  - Latch cur_ptr=in_ptr, cur_addr={0,in_h1}, cur_alt={1,in_h2}, mode=FIRST, kicks=0.
  - Next cycle: pat_we=1, pat_addr=in_ptr, pat_din=in_pattern, for exactly 1 cycle.
  - Enter RD, which issues the shadow read at cur_addr.
- CHK (shadow data available), occupant O = {ov, optr, oalt}:
  - ov=0: write shadow[cur_addr]={1,cur_ptr,cur_alt} and index RAM (idx_we=1, idx_addr=cur_addr, idx_din=cur_ptr). Go to DONE with fail=0.
  - ov=1, mode=FIRST: swap cur_addr and cur_alt, set mode=SECOND, go to RD.
  - ov=1, mode=SECOND or KICKED, kicks<MAX_KICKS:
    - Write cur into cur_addr in shadow and index RAM, evicting O.
    - Then cur_ptr=optr, cur_alt=cur_addr, cur_addr=oalt, kicks+=1, mode=KICKED; go to RD.
  - ov=1, mode SECOND/KICKED, kicks==MAX_KICKS: no write; go to DONE with fail=1 and done_ptr=cur_ptr.
- DONE: done_valid=1 for 1 cycle with done_fail, done_ptr and done_kicks=kicks. Return to IDLE; in_ready is high the following cycle.
- Latency with no collision: accept at cycle 0, RD 1, CHK 2 (index write), done_valid at cycle 3.
- Each additional probe or kick adds 2 cycles.
- idx_we and pat_we are never high in the same cycle as a stale address. Write outputs return to 0 whenever the strobe is 0.
- A duplicate ptr is not detected. The caller guarantees unique pointers.
- rst asserted mid-insert aborts the insert: no done pulse, full INIT sweep restarts, and the shadow and index RAM contents are cleared.
- in_valid while not ready is ignored; no request is buffered.

Optional Feature:
- CUCKOO_LOADER_STATS_EN defined: adds outputs stat_inserts[15:0] and stat_fails[15:0].
  - Both are saturating counters, cleared by rst.
  - Incremented on done_valid with done_fail=0 or done_fail=1 respectively.
- Not defined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst for 3 cycles -> idx_we high with idx_addr 0..2047 and idx_din=0; in_ready=1 exactly at cycle 2048 after release.
- Empty insert h1=5, h2=7, ptr=3, pattern=0xABC -> pat_we at cycle 1 (addr 3); idx_we at cycle 2 with addr 0x005 and din 3; done_valid at cycle 3, fail=0, kicks=0.
- T1 collision: insert (5,7,3), then (5,9,4) -> second insert writes idx_addr 0x409 din 4; kicks=0; 2 extra cycles.
- Single kick:
  - Insert A(5,7,1), B(5,7,2), C(5,7,3).
  - C evicts B at 0x407. B is then placed at 0x005? No: 0x005 holds A, so B kicks A, A goes to its alt 0x407 and kicks C, and so on.
  - -> ping-pong ends in fail at kicks=16, with done_ptr equal to the displaced ptr and done_fail=1.
- Reset mid-insert: rst asserted during a kick chain -> no done_valid; new INIT sweep; a later lookup of 0x005 returns idx_din=0.
- With CUCKOO_LOADER_STATS_EN: 3 successful inserts and 1 fail -> stat_inserts=3, stat_fails=1.
